// File: rtl/mips_pkg.sv
// Shared types for the MIPS fetch front end: queue entry layout, fetch
// state encoding and the sequential fetch stride.
package mips_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a dominant flush; the head entry
// is presented combinationally from storage.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage has no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches over req/ack,
// buffers them in fetch_fifo and hands {pc, inst} to decode; redirects flush.
module if_prefetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [31:0]            id_inst,
  output logic [31:0]            id_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         push;
  logic         pop;
  logic         room_after;

  assign id_valid   = (occupancy != '0);
  assign id_inst    = head.inst;
  assign id_pc      = head.pc;
  assign pop        = id_valid && id_ready;
  assign push       = (state == FETCH) && imem_ack && !redirect;
  assign push_entry = '{pc: fetch_pc, inst: imem_rdata};

  // After this push (and any same-cycle pop) another slot is still free.
  assign room_after = (occupancy - CNT_W'(pop)) < CNT_W'(DEPTH - 1);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_entry (push_entry),
    .head       (head),
    .count      (occupancy)
  );

  // fetch_pc tracks the next address to issue; imem_addr stays frozen on the
  // in-flight address, which matters in DISCARD after a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end else if (occupancy < CNT_W'(DEPTH)) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        FETCH: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            if (imem_ack) begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end else begin
              state <= DISCARD;
            end
          end else if (imem_ack) begin
            fetch_pc  <= fetch_pc + PC_INCR;
            imem_addr <= fetch_pc + PC_INCR;
            if (!room_after) begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (redirect) fetch_pc <= redirect_pc;
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: directed scenarios plus a
// randomized run scored against a stream-level model of the fetch queue.
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   redirect = 1'b0;
  logic [31:0]            redirect_pc = 32'h0;
  logic                   imem_req;
  logic [31:0]            imem_addr;
  logic                   imem_ack;
  logic [31:0]            imem_rdata;
  logic                   id_valid;
  logic                   id_ready = 1'b0;
  logic [31:0]            id_inst;
  logic [31:0]            id_pc;
  logic [$clog2(DEPTH):0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 0;
  int wait_cnt;

  always #5 clk = ~clk;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .occupancy   (occupancy)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0123;
  endfunction

  // Instruction memory: acks once a request has waited `lat` cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= 0;
    else if (imem_req && imem_ack) wait_cnt <= 0;
    else if (imem_req) wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_ack ? inst_of(imem_addr) : 32'hDEAD_BEEF;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; redirect = 1'b0; id_ready = 1'b0; lat = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; redirect = 1'b0; id_ready = 1'b0; lat = 0;
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    n_tests++; if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_tests++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    @(negedge clk); #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_hold_req: got %b want 0", imem_req); end
  endtask

  task automatic test_sequential();
    do_reset();
    id_ready = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL seq_early_valid: got %b want 0", id_valid); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_fail++; $display("FAIL seq_first_req: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_pc;
      exp_pc = RESET_PC + 32'(4 * i);
      @(negedge clk); #1;
      n_tests++; if (id_valid !== 1'b1 || id_pc !== exp_pc) begin n_fail++; $display("FAIL seq_pc[%0d]: got valid=%b pc=%h want 1/%h", i, id_valid, id_pc, exp_pc); end
      n_tests++; if (id_inst !== inst_of(exp_pc)) begin n_fail++; $display("FAIL seq_inst[%0d]: got %h want %h", i, id_inst, inst_of(exp_pc)); end
    end
  endtask

  task automatic test_fill();
    int acks;
    acks = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (imem_req && imem_ack) acks++;
    end
    n_tests++; if (acks !== 4) begin n_fail++; $display("FAIL fill_acks: got %0d want 4", acks); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fill_req_drop: got %b want 0", imem_req); end
    n_tests++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL fill_occ: got %0d want 4", occupancy); end
    n_tests++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL fill_head: got %h want 0", id_pc); end
    @(negedge clk); id_ready = 1'b1;
    @(negedge clk); id_ready = 1'b0; #1;
    n_tests++; if (occupancy !== 3'd3 || id_pc !== 32'h4) begin n_fail++; $display("FAIL fill_pop: got occ=%0d pc=%h want 3/4", occupancy, id_pc); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fill_req_after_pop: got %b want 0", imem_req); end
    @(negedge clk); #1;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL fill_refetch: got req=%b addr=%h want 1/10", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_pending();
    bit found, seen_new, saw_ack8, bad_addr, leaked;
    found = 0; seen_new = 0; saw_ack8 = 0; bad_addr = 0; leaked = 0;
    do_reset();
    id_ready = 1'b1; lat = 3;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #1;
      if (imem_req && imem_addr == 32'h8) found = 1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rp_find_req8: got none want request to 8"); end
    redirect = 1'b1; redirect_pc = 32'h400;
    @(negedge clk); redirect = 1'b0; #1;
    n_tests++; if (occupancy !== '0) begin n_fail++; $display("FAIL rp_flush: got %0d want 0", occupancy); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL rp_discard_hold: got req=%b addr=%h want 1/8", imem_req, imem_addr); end
    for (int i = 0; i < 30 && !seen_new; i++) begin
      if (id_valid) leaked = 1;
      if (imem_req && imem_addr == 32'h400) seen_new = 1;
      else if (imem_req && imem_addr != 32'h8) bad_addr = 1;
      else if (imem_req && imem_ack) saw_ack8 = 1;
      if (!seen_new) begin @(negedge clk); #1; end
    end
    n_tests++; if (!saw_ack8) begin n_fail++; $display("FAIL rp_ack8: got no ack want ack of stale request"); end
    n_tests++; if (bad_addr) begin n_fail++; $display("FAIL rp_addr_stable: got changed addr want 8 until ack"); end
    n_tests++; if (!seen_new) begin n_fail++; $display("FAIL rp_new_req: got none want request to 400"); end
    n_tests++; if (leaked) begin n_fail++; $display("FAIL rp_leak: got id_valid=1 want 0 before new data"); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #1;
      if (id_valid) found = 1;
    end
    n_tests++; if (!found || id_pc !== 32'h400 || id_inst !== inst_of(32'h400)) begin n_fail++; $display("FAIL rp_first_pc: got valid=%b pc=%h inst=%h want 1/400/%h", found, id_pc, id_inst, inst_of(32'h400)); end
    lat = 0;
  endtask

  task automatic test_redirect_collision();
    do_reset();
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (occupancy !== 3'd2 || imem_ack !== 1'b1) begin n_fail++; $display("FAIL rc_setup: got occ=%0d ack=%b want 2/1", occupancy, imem_ack); end
    redirect = 1'b1; redirect_pc = 32'h200; id_ready = 1'b1;
    @(negedge clk); redirect = 1'b0; id_ready = 1'b0; #1;
    n_tests++; if (occupancy !== '0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL rc_flush: got occ=%0d valid=%b want 0/0", occupancy, id_valid); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rc_idle: got req=%b want 0", imem_req); end
    @(negedge clk); #1;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rc_new_req: got req=%b addr=%h want 1/200", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_tests++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || occupancy !== 3'd1) begin n_fail++; $display("FAIL rc_first_pc: got valid=%b pc=%h occ=%0d want 1/200/1", id_valid, id_pc, occupancy); end
  endtask

  task automatic test_wrap();
    logic [31:0] got_pc [3];
    logic [31:0] got_inst [3];
    logic [31:0] exp_pc [3];
    int k;
    k = 0;
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    do_reset();
    id_ready = 1'b1;
    repeat (3) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk); redirect = 1'b0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      #1;
      if (id_valid && id_ready) begin got_pc[k] = id_pc; got_inst[k] = id_inst; k++; end
      @(negedge clk);
    end
    n_tests++; if (k !== 3) begin n_fail++; $display("FAIL wrap_count: got %0d pops want 3", k); end
    for (int i = 0; i < k; i++) begin
      n_tests++; if (got_pc[i] !== exp_pc[i] || got_inst[i] !== inst_of(exp_pc[i])) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h/%h want %h/%h", i, got_pc[i], got_inst[i], exp_pc[i], inst_of(exp_pc[i])); end
    end
    id_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    lat = 2;
    repeat (5) @(negedge clk);
    #1;
    n_tests++; if (imem_req !== 1'b1 || imem_ack !== 1'b0) begin n_fail++; $display("FAIL ar_setup: got req=%b ack=%b want 1/0", imem_req, imem_ack); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL ar_immediate: got req=%b valid=%b want 0/0", imem_req, id_valid); end
    n_tests++; if (occupancy !== '0 || imem_addr !== RESET_PC) begin n_fail++; $display("FAIL ar_state: got occ=%0d addr=%h want 0/%h", occupancy, imem_addr, RESET_PC); end
    @(negedge clk); rst = 1'b1; lat = 0;
    @(negedge clk); #1;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_fail++; $display("FAIL ar_restart: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC); end
    @(negedge clk); #1;
    n_tests++; if (id_valid !== 1'b1 || id_pc !== RESET_PC) begin n_fail++; $display("FAIL ar_first_pc: got valid=%b pc=%h want 1/%h", id_valid, id_pc, RESET_PC); end
  endtask

  // Stream-level model: decode must see consecutive words from the latest
  // redirect target; occupancy is accepted fills minus pops since the flush.
  task automatic test_random();
    logic [31:0] exp_pc, prev_addr;
    int  model_occ;
    bit  stale, prev_pending, pop, ack;
    do_reset();
    exp_pc = RESET_PC; model_occ = 0; stale = 0; prev_pending = 0; prev_addr = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      id_ready    = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      if (wait_cnt == 0) lat = $urandom_range(0, 3);
      #1;
      n_tests++; if (int'(occupancy) !== model_occ) begin n_fail++; $display("FAIL rnd_occ@%0d: got %0d want %0d", cyc, occupancy, model_occ); end
      n_tests++; if (id_valid !== (model_occ != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, id_valid, model_occ != 0); end
      if (prev_pending) begin
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_hold@%0d: got req=%b addr=%h want 1/%h", cyc, imem_req, imem_addr, prev_addr); end
      end
      pop = id_valid && id_ready;
      ack = imem_req && imem_ack;
      if (pop && !redirect) begin
        n_tests++; if (id_pc !== exp_pc || id_inst !== inst_of(exp_pc)) begin n_fail++; $display("FAIL rnd_pop@%0d: got %h/%h want %h/%h", cyc, id_pc, id_inst, exp_pc, inst_of(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) begin
        model_occ = 0;
        exp_pc    = redirect_pc;
        stale     = imem_req && !ack;
      end else begin
        if (ack && !stale) model_occ++;
        if (ack) stale = 0;
        if (pop) model_occ--;
      end
      prev_pending = imem_req && !ack;
      prev_addr    = imem_addr;
    end
    redirect = 1'b0; id_ready = 1'b0; lat = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_fill();
    test_redirect_pending();
    test_redirect_collision();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
